// File: rtl/sumador_serial_pkg.sv
// sumador_serial_pkg: shared state encodings and default operand width
// for the bit-serial minuend reconstruction unit.
package sumador_serial_pkg;

  // Default operand width in bits.
  localparam int DEFAULT_WIDTH = 4;

  // Controller states; encodings are fixed so they match the rest of the ALU.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : sumador_serial_pkg

// File: rtl/sumador_serial_if.sv
// sumador_serial_if: request/result bundle between the ALU self-check path
// (master) and the serial reconstruction unit (slave).
interface sumador_serial_if
  import sumador_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] Resultado;
  logic             Signo;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] A;
  logic             C_out;
  logic             busy;
  logic             done;

  // Requester side: drives the operands, observes the result.
  modport master (
    output start, Resultado, Signo, B,
    input  A, C_out, busy, done
  );

  // Unit side: consumes the operands, produces the result.
  modport slave (
    input  start, Resultado, Signo, B,
    output A, C_out, busy, done
  );

endinterface : sumador_serial_if

// File: rtl/sumador_completo.sv
// sumador_completo: 1-bit full adder, the only arithmetic element of the
// serial datapath.
module sumador_completo (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule : sumador_completo

// File: rtl/sumador_serial.sv
// sumador_serial: recovers A = B +/- Resultado one bit per clock using a
// single full adder. The subtract case is done as B + ~Resultado + 1, with
// the +1 injected as the initial carry. Results are published only in DONE
// so A/C_out stay stable while a computation is in flight.
module sumador_serial
  import sumador_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  sumador_serial_if.slave  bus
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] a_sh;
  logic             signo_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_q;
  logic             c_out_q;
  logic             busy_q;
  logic             done_q;

  logic             fa_b;
  logic             fa_s;
  logic             fa_cout;

  // Conditionally invert the magnitude bit so subtraction becomes addition.
  always_comb begin
    fa_b = r_sh[0] ^ signo_q;
  end

  sumador_completo u_fa (
    .a    (b_sh[0]),
    .b    (fa_b),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State register; reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state: accept start only in IDLE, run WIDTH bit steps, publish once.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_next = ST_CALC;
      ST_CALC: if (cnt == LAST) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Serial datapath: latch operands on acceptance, then one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh    <= '0;
      b_sh    <= '0;
      a_sh    <= '0;
      signo_q <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            r_sh    <= bus.Resultado;
            b_sh    <= bus.B;
            signo_q <= bus.Signo;
            carry   <= bus.Signo;
            a_sh    <= '0;
            cnt     <= '0;
          end
        end
        ST_CALC: begin
          a_sh  <= {fa_s, a_sh} >> 1;
          r_sh  <= r_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers only change in DONE, so they hold between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      c_out_q <= 1'b0;
    end else if (state == ST_DONE) begin
      a_q     <= a_sh;
      c_out_q <= carry ^ signo_q;
    end
  end

  // Status flags: done pulses alongside the result; busy covers the pulse too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= (state == ST_DONE);
      busy_q <= (state_next != ST_IDLE) || (state == ST_DONE);
    end
  end

  assign bus.A     = a_q;
  assign bus.C_out = c_out_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule : sumador_serial

// File: tb/tb_sumador_serial.sv
// tb_sumador_serial: directed checks of the serial minuend reconstruction
// unit with hand-computed expected values.
module tb_sumador_serial;
  import sumador_serial_pkg::*;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sumador_serial_if #(.WIDTH(WIDTH)) bus ();

  sumador_serial #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Safety net so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive(input logic [WIDTH-1:0] r, input logic s, input logic [WIDTH-1:0] b);
    bus.Resultado = r;
    bus.Signo     = s;
    bus.B         = b;
  endtask

  task automatic wait_done(input int budget, output bit seen, output int cycles);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  // One-cycle start pulse, then wait for done; returns at the done negedge.
  task automatic run_op(input logic [WIDTH-1:0] r, input logic s, input logic [WIDTH-1:0] b,
                        output bit seen);
    int cycles;
    @(negedge clk);
    drive(r, s, b);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(WIDTH + 4, seen, cycles);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    drive('0, 1'b0, '0);
    repeat (2) @(negedge clk);
    n_vec++; if (bus.A !== 4'd0)    begin n_err++; $display("[TB] FAIL reset_A got=%0d want=0", bus.A); end
    n_vec++; if (bus.C_out !== 1'b0) begin n_err++; $display("[TB] FAIL reset_C_out got=%b want=0", bus.C_out); end
    n_vec++; if (bus.busy !== 1'b0)  begin n_err++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0)  begin n_err++; $display("[TB] FAIL reset_done got=%b want=0", bus.done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_latency();
    @(negedge clk);
    drive(4'd5, 1'b0, 4'd3);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("[TB] FAIL add_busy_rise got=%b want=1", bus.busy); end
    for (int i = 1; i <= WIDTH; i++) begin
      @(negedge clk);
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("[TB] FAIL add_done_early cycle=%0d got=%b want=0", i, bus.done); end
      n_vec++; if (bus.A !== 4'd0)    begin n_err++; $display("[TB] FAIL add_A_hold cycle=%0d got=%0d want=0", i, bus.A); end
    end
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b1)  begin n_err++; $display("[TB] FAIL add_done_pulse got=%b want=1", bus.done); end
    n_vec++; if (bus.A !== 4'd8)     begin n_err++; $display("[TB] FAIL add_A got=%0d want=8", bus.A); end
    n_vec++; if (bus.C_out !== 1'b0) begin n_err++; $display("[TB] FAIL add_C_out got=%b want=0", bus.C_out); end
    n_vec++; if (bus.busy !== 1'b1)  begin n_err++; $display("[TB] FAIL add_busy_at_done got=%b want=1", bus.busy); end
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b0)  begin n_err++; $display("[TB] FAIL add_done_fall got=%b want=0", bus.done); end
    n_vec++; if (bus.busy !== 1'b0)  begin n_err++; $display("[TB] FAIL add_busy_fall got=%b want=0", bus.busy); end
    n_vec++; if (bus.A !== 4'd8)     begin n_err++; $display("[TB] FAIL add_A_hold_after got=%0d want=8", bus.A); end
  endtask

  task automatic test_subtract();
    bit seen;
    run_op(4'd2, 1'b1, 4'd7, seen);
    n_vec++; if (!seen)              begin n_err++; $display("[TB] FAIL sub_timeout got=no_done want=done"); end
    n_vec++; if (bus.A !== 4'd5)     begin n_err++; $display("[TB] FAIL sub_A got=%0d want=5", bus.A); end
    n_vec++; if (bus.C_out !== 1'b0) begin n_err++; $display("[TB] FAIL sub_C_out got=%b want=0", bus.C_out); end
  endtask

  task automatic test_range_error();
    bit seen;
    run_op(4'd9, 1'b0, 4'd9, seen);
    n_vec++; if (!seen)              begin n_err++; $display("[TB] FAIL ovf_timeout got=no_done want=done"); end
    n_vec++; if (bus.A !== 4'd2)     begin n_err++; $display("[TB] FAIL ovf_A got=%0d want=2", bus.A); end
    n_vec++; if (bus.C_out !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_C_out got=%b want=1", bus.C_out); end
    run_op(4'd8, 1'b1, 4'd3, seen);
    n_vec++; if (!seen)              begin n_err++; $display("[TB] FAIL udf_timeout got=no_done want=done"); end
    n_vec++; if (bus.A !== 4'd11)    begin n_err++; $display("[TB] FAIL udf_A got=%0d want=11", bus.A); end
    n_vec++; if (bus.C_out !== 1'b1) begin n_err++; $display("[TB] FAIL udf_C_out got=%b want=1", bus.C_out); end
  endtask

  task automatic test_start_ignored();
    int             done_cnt = 0;
    bit             busy_gap = 1'b0;
    logic [WIDTH-1:0] a_seen = '0;
    @(negedge clk);
    drive(4'd1, 1'b0, 4'd2);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= WIDTH + 6; c++) begin
      @(negedge clk);
      if (c == 2) begin
        drive(4'd7, 1'b0, 4'd7);
        bus.start = 1'b1;
      end
      if (c == 3) bus.start = 1'b0;
      if (c <= WIDTH + 1 && bus.busy !== 1'b1) busy_gap = 1'b1;
      if (bus.done === 1'b1) begin
        done_cnt++;
        a_seen = bus.A;
      end
    end
    n_vec++; if (done_cnt != 1)    begin n_err++; $display("[TB] FAIL ign_done_count got=%0d want=1", done_cnt); end
    n_vec++; if (a_seen !== 4'd3)  begin n_err++; $display("[TB] FAIL ign_A got=%0d want=3", a_seen); end
    n_vec++; if (busy_gap)         begin n_err++; $display("[TB] FAIL ign_busy_gap got=dropped want=continuous"); end
  endtask

  task automatic test_reset_abort();
    bit seen;
    bit spurious = 1'b0;
    @(negedge clk);
    drive(4'd6, 1'b0, 4'd6);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.A !== 4'd0)     begin n_err++; $display("[TB] FAIL abort_A got=%0d want=0", bus.A); end
    n_vec++; if (bus.C_out !== 1'b0) begin n_err++; $display("[TB] FAIL abort_C_out got=%b want=0", bus.C_out); end
    n_vec++; if (bus.busy !== 1'b0)  begin n_err++; $display("[TB] FAIL abort_busy got=%b want=0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0)  begin n_err++; $display("[TB] FAIL abort_done got=%b want=0", bus.done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < WIDTH + 4; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious = 1'b1;
    end
    n_vec++; if (spurious) begin n_err++; $display("[TB] FAIL abort_resume got=activity want=idle"); end
    run_op(4'd0, 1'b1, 4'd15, seen);
    n_vec++; if (!seen)              begin n_err++; $display("[TB] FAIL zero_neg_timeout got=no_done want=done"); end
    n_vec++; if (bus.A !== 4'd15)    begin n_err++; $display("[TB] FAIL zero_neg_A got=%0d want=15", bus.A); end
    n_vec++; if (bus.C_out !== 1'b0) begin n_err++; $display("[TB] FAIL zero_neg_C_out got=%b want=0", bus.C_out); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int cycles;
    int r;
    bit s;
    @(negedge clk);
    bus.start = 1'b1;
    for (int a = 0; a <= 14; a++) begin
      for (int b = 0; b <= 14; b++) begin
        if (a >= b) begin r = a - b; s = 1'b0; end
        else        begin r = b - a; s = 1'b1; end
        drive(r[WIDTH-1:0], s, b[WIDTH-1:0]);
        wait_done(WIDTH + 4, seen, cycles);
        n_vec++;
        if (!seen || cycles != WIDTH + 2) begin
          n_err++;
          $display("[TB] FAIL b2b_spacing a=%0d b=%0d got=%0d want=%0d", a, b, cycles, WIDTH + 2);
        end
        n_vec++;
        if (bus.A !== a[WIDTH-1:0]) begin
          n_err++;
          $display("[TB] FAIL b2b_A a=%0d b=%0d got=%0d want=%0d", a, b, bus.A, a);
        end
        n_vec++;
        if (bus.C_out !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL b2b_C_out a=%0d b=%0d got=%b want=0", a, b, bus.C_out);
        end
      end
    end
    bus.start = 1'b0;
    repeat (WIDTH + 3) @(negedge clk);
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_add_latency();
    test_subtract();
    test_range_error();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sumador_serial
